// File: rtl/smp8_pkg.sv
// smp8 shared definitions: memory geometry,
// default frame marker and loader states.
package smp8_pkg;
  localparam int MEM_DEPTH = 32;
  localparam int MEM_AW = 5;
  localparam logic [7:0] DEFAULT_SYNC = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    DONE,
    ERR
  } loader_state_t;
endpackage

// File: rtl/smp8_idle_timer.sv
// Inter-byte idle counter; expired fires on the
// TIMEOUT-th consecutive idle edge while running.
module smp8_idle_timer #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !run)
      cnt_d = '0;
    else if (cnt_q != LAST)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expired = run && !clear && (cnt_q == LAST);
endmodule

// File: rtl/smp8_prog_loader.sv
// Byte-stream program loader: writes a checksummed
// image into smp8 memory and holds the CPU until done.
module smp8_prog_loader
  import smp8_pkg::*;
#(
  parameter int TIMEOUT = 1000,
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);
  loader_state_t state_q, state_d;
  logic [5:0] len_q, len_d;
  logic [5:0] cnt_q, cnt_d;
  logic [7:0] sum_q, sum_d;
  logic we_q, we_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic hold_q, hold_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic accept, expired, in_frame;

  assign in_ready = !reset;
  assign accept = in_valid && in_ready;
  assign in_frame = (state_q == LEN) || (state_q == DATA)
                 || (state_q == CSUM);

  smp8_idle_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .run    (in_frame),
    .expired(expired)
  );

  always_comb begin
    state_d = state_q;
    len_d = len_q;
    cnt_d = cnt_q;
    sum_d = sum_q;
    we_d = 1'b0;
    addr_d = addr_q;
    wdata_d = wdata_q;
    hold_d = hold_q;
    done_d = done_q;
    err_d = err_q;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (accept && in_data == SYNC_BYTE) begin
          state_d = LEN;
          hold_d = 1'b1;
          done_d = 1'b0;
          err_d = 1'b0;
        end
      end
      LEN: begin
        if (accept) begin
          if (in_data == 8'd0 || in_data > 8'(MEM_DEPTH)) begin
            state_d = ERR;
            err_d = 1'b1;
          end else begin
            len_d = in_data[5:0];
            cnt_d = '0;
            sum_d = '0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          we_d = 1'b1;
          addr_d = cnt_q[MEM_AW-1:0];
          wdata_d = in_data;
          sum_d = sum_q + in_data;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == len_q - 6'd1)
            state_d = CSUM;
        end
      end
      CSUM: begin
        if (accept) begin
          if (in_data == sum_q) begin
            state_d = DONE;
            done_d = 1'b1;
            hold_d = 1'b0;
          end else begin
            state_d = ERR;
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // An arriving byte takes precedence over expiry
    if (!accept && expired) begin
      state_d = ERR;
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q <= '0;
      cnt_q <= '0;
      sum_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      hold_q <= 1'b1;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      hold_q <= hold_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end

  assign mem_we = we_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_hold = hold_q;
  assign load_done = done_q;
  assign load_err = err_q;
endmodule
